tmul_ctrl: RTL

Sequencer for the 8×8 tile multiplier (`TMUL_32_8mul8`). It loads one B tile row by row into a held register and then streams A vectors into the multiplier under valid/ready. It tracks results in flight through the multiplier's fixed latency and buffers them in a small result FIFO. Issue is credit-limited, so a stalled consumer never drops a product. It sits between the DMA/operand fetch and the writeback path of the tile unit.

---
 rtl/tmul_pkg.sv | 32 +++
 rtl/tmul_res_fifo.sv | 59 +++++
 rtl/tmul_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/tmul_pkg.sv
// tmul_pkg: shared types, default geometry and lane-slice helpers for the
// tile-multiplier sequencer.
package tmul_pkg;

    localparam int TMUL_DW = 32;
    localparam int TMUL_N  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_B = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } tmul_state_e;

    // Row j of a packed B tile (default geometry).
    function automatic logic [TMUL_N*TMUL_DW-1:0] tmul_row(
        input logic [TMUL_N*TMUL_N*TMUL_DW-1:0] tile,
        input int                                j
    );
        return tile[j*TMUL_N*TMUL_DW +: TMUL_N*TMUL_DW];
    endfunction

    // Lane k of a packed result vector (default geometry).
    function automatic logic [2*TMUL_DW-1:0] tmul_res_lane(
        input logic [TMUL_N*2*TMUL_DW-1:0] res,
        input int                          k
    );
        return res[k*2*TMUL_DW +: 2*TMUL_DW];
    endfunction

endpackage

// File: rtl/tmul_res_fifo.sv
// tmul_res_fifo: synchronous result FIFO with occupancy count. The head reads
// as zero while empty so the downstream data bus is quiet when nothing is valid.
module tmul_res_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [W-1:0]               wdata_i,
    input  logic                       pop_i,
    output logic [W-1:0]               rdata_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // A push into a full FIFO is only taken when a pop frees a slot in the same cycle.
    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; the head is masked while empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign empty_o = (count_q == '0);
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/tmul_ctrl.sv
// tmul_ctrl: sequencer for the 8x8 tile multiplier. Loads a B tile row by
// row, streams A vectors under credit control, tracks products through the
// multiplier latency and buffers them in a result FIFO.
// Optional: define TMUL_CTRL_PERF_EN to build the issue-stall counter.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start; num_vec captured on start
// ST_LOAD_B | accepting B rows 0..N-1 into the held tile
// ST_ISSUE  | issuing A vectors while issue count and credit allow
// ST_DRAIN  | waiting for delay line and result FIFO to empty
// ST_DONE   | single-cycle done pulse
module tmul_ctrl
    import tmul_pkg::*;
#(
    parameter int DW        = TMUL_DW,
    parameter int N         = TMUL_N,
    parameter int MUL_LAT   = 1,
    parameter int RES_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            num_vec,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [N*DW-1:0]       b_row,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [N*DW-1:0]       a_vec,
    output logic [N*DW-1:0]       mul_a,
    output logic [N*N*DW-1:0]     mul_b,
    input  logic [N*2*DW-1:0]     mul_c,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic [N*2*DW-1:0]     r_data,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           perf_stall_cnt
);

    localparam int RW = N * 2 * DW;
    localparam int CW = $clog2(RES_DEPTH) + 1;

    tmul_state_e          state_q, state_d;
    logic [7:0]           num_vec_q, num_vec_d;
    logic [7:0]           row_cnt_q, row_cnt_d;
    logic [7:0]           issued_q, issued_d;
    logic [MUL_LAT-1:0]   dl_q, dl_d;
    logic [N*DW-1:0]      mul_a_q;
    logic [N*DW-1:0]      b_tile_q [N];
    logic                 b_hs, a_hs, credit_ok, push, fifo_empty;
    logic [CW-1:0]        fifo_cnt;

    // Next-state, counters and handshake readiness.
    always_comb begin
        state_d   = state_q;
        num_vec_d = num_vec_q;
        row_cnt_d = row_cnt_q;
        issued_d  = issued_q;
        b_ready   = 1'b0;
        a_ready   = 1'b0;
        // Every product in the delay line already owns a FIFO slot.
        credit_ok = ($countones(dl_q) + int'(fifo_cnt)) < RES_DEPTH;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_vec_d = num_vec;
                    row_cnt_d = '0;
                    issued_d  = '0;
                    state_d   = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                b_ready = 1'b1;
                if (b_valid) begin
                    row_cnt_d = row_cnt_q + 8'd1;
                    if (row_cnt_q == 8'(N - 1))
                        state_d = (num_vec_q == 8'd0) ? ST_DRAIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                a_ready = (issued_q < num_vec_q) && credit_ok;
                if (a_valid && a_ready) begin
                    issued_d = issued_q + 8'd1;
                    if (issued_q == num_vec_q - 8'd1) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((dl_q == '0) && fifo_empty) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        b_hs  = b_ready && b_valid;
        a_hs  = a_ready && a_valid;
        dl_d    = dl_q << 1;
        dl_d[0] = a_hs;
    end

    // State, counters, delay line and A operand register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            num_vec_q <= '0;
            row_cnt_q <= '0;
            issued_q  <= '0;
            dl_q      <= '0;
            mul_a_q   <= '0;
        end else begin
            state_q   <= state_d;
            num_vec_q <= num_vec_d;
            row_cnt_q <= row_cnt_d;
            issued_q  <= issued_d;
            dl_q      <= dl_d;
            if (a_hs) mul_a_q <= a_vec;
        end
    end

    // Held B tile; each row is rewritten only by its own LOAD_B handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < N; j++) b_tile_q[j] <= '0;
        end else begin
            for (int j = 0; j < N; j++)
                if (b_hs && (row_cnt_q == 8'(j))) b_tile_q[j] <= b_row;
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_mul_b
        assign mul_b[j*N*DW +: N*DW] = b_tile_q[j];
    end

    assign push    = dl_q[MUL_LAT-1];
    assign mul_a   = mul_a_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign r_valid = !fifo_empty;

    tmul_res_fifo #(
        .W     (RW),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (push),
        .wdata_i (mul_c),
        .pop_i   (r_valid && r_ready),
        .rdata_o (r_data),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

`ifdef TMUL_CTRL_PERF_EN
    logic [31:0] perf_q;

    // Saturating count of ISSUE cycles where an offered vector was refused.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_q <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            perf_q <= '0;
        end else if ((state_q == ST_ISSUE) && a_valid && !a_ready && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule
